// File: rtl/noc_packetizer_pkg.sv
// NoC packetizer shared constants, flit layouts and FSM states.
// Head/tail flits are overlaid on the 128-bit flit as packed structs.
package Noc_parameters;

    localparam int Noc_Data_Width = 128;
    localparam int Noc_X_Size = 3;
    localparam int Noc_Y_Size = 3;
    localparam int Noc_ID_X_Width = 2;
    localparam int Noc_ID_Y_Width = 2;
    localparam int Noc_ID_Width = Noc_ID_X_Width + Noc_ID_Y_Width;
    localparam int Noc_VC_Channel = 4;
    localparam int Noc_VC_Width = $clog2(Noc_VC_Channel);

    localparam int Noc_Point_H = 124;
    localparam int Noc_Source_Point = Noc_Point_H - Noc_ID_Width;
    localparam int Noc_Dest_Point = Noc_Source_Point - Noc_ID_Width;
    localparam int Axi_Type_Point = Noc_Dest_Point - 3;
    localparam int Axi_Pack_Order_Point = Axi_Type_Point - 8;
    localparam int Axi_Len_Point = Axi_Pack_Order_Point - 8;
    localparam int Noc_Point_E = Axi_Len_Point - 4;
    localparam int Less_Byte = Noc_Point_E;
    localparam int Noc_Tail_E_Width = 4;

    localparam logic [3:0] Noc_Head_H = 4'hA;
    localparam logic [3:0] Noc_Head_E = 4'hB;
    localparam logic [3:0] Noc_Tail_H = 4'hC;
    localparam logic [3:0] Noc_Tail_E = 4'hD;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY,
        TAIL
    } pkt_state_e;

    typedef struct packed {
        logic [Noc_Data_Width-Noc_Point_H-1:0]         hdr;
        logic [Noc_Point_H-Noc_Source_Point-1:0]       src;
        logic [Noc_Source_Point-Noc_Dest_Point-1:0]    dst;
        logic [Noc_Dest_Point-Axi_Type_Point-1:0]      axi_type;
        logic [Axi_Type_Point-Axi_Pack_Order_Point-1:0] order;
        logic [Axi_Pack_Order_Point-Axi_Len_Point-1:0] len;
        logic [Axi_Len_Point-Noc_Point_E-1:0]          tag;
        logic [Less_Byte-1:0]                          pad;
    } head_flit_t;

    typedef struct packed {
        logic [Noc_Data_Width-Noc_Point_H-1:0]      hdr;
        logic [Noc_Point_H-Noc_Source_Point-1:0]    src;
        logic [Noc_Source_Point-Noc_Dest_Point-1:0] dst;
        logic [Noc_Dest_Point-Noc_Tail_E_Width-1:0] pad;
        logic [Noc_Tail_E_Width-1:0]                tag;
    } tail_flit_t;

endpackage

// File: rtl/noc_packetizer.sv
// Turns a request plus payload beats into head/body/tail NoC flits.
// The flit output is a single register stage with valid/ready backpressure.
module noc_packetizer
    import Noc_parameters::*;
#(
    parameter logic [Noc_ID_X_Width-1:0] SRC_X = '0,
    parameter logic [Noc_ID_Y_Width-1:0] SRC_Y = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [Noc_ID_X_Width-1:0] req_dest_x,
    input  logic [Noc_ID_Y_Width-1:0] req_dest_y,
    input  logic [2:0]                req_type,
    input  logic [7:0]                req_order,
    input  logic [7:0]                req_len,
    input  logic [Noc_VC_Width-1:0]   req_vc,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [Noc_Data_Width-1:0] data,
    output logic                      flit_valid,
    input  logic                      flit_ready,
    output logic [Noc_Data_Width-1:0] flit_data,
    output logic [Noc_VC_Width-1:0]   flit_vc,
    output logic                      err
);

    pkt_state_e state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [Noc_ID_X_Width-1:0] cap_x, cap_x_n;
    logic [Noc_ID_Y_Width-1:0] cap_y, cap_y_n;
    logic [2:0] cap_type, cap_type_n;
    logic [7:0] cap_order, cap_order_n;
    logic [7:0] cap_len, cap_len_n;
    logic [Noc_VC_Width-1:0] cap_vc, cap_vc_n;
    logic fv_n, err_n;
    logic [Noc_Data_Width-1:0] fd_n;
    logic [Noc_VC_Width-1:0] fvc_n;
    logic load_en, bad_dest;
    head_flit_t head_f;
    tail_flit_t tail_f;

    assign load_en = !flit_valid || flit_ready;

    assign bad_dest =
        ({1'b0, req_dest_x} >= (Noc_ID_X_Width + 1)'(Noc_X_Size)) ||
        ({1'b0, req_dest_y} >= (Noc_ID_Y_Width + 1)'(Noc_Y_Size));

    always_comb begin
        head_f = '0;
        head_f.hdr = Noc_Head_H;
        head_f.src = {SRC_X, SRC_Y};
        head_f.dst = {cap_x, cap_y};
        head_f.axi_type = cap_type;
        head_f.order = cap_order;
        head_f.len = cap_len;
        head_f.tag = Noc_Head_E;
        tail_f = '0;
        tail_f.hdr = Noc_Tail_H;
        tail_f.src = {SRC_X, SRC_Y};
        tail_f.dst = {cap_x, cap_y};
        tail_f.tag = Noc_Tail_E;
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cap_x_n = cap_x;
        cap_y_n = cap_y;
        cap_type_n = cap_type;
        cap_order_n = cap_order;
        cap_len_n = cap_len;
        cap_vc_n = cap_vc;
        fv_n = flit_valid;
        fd_n = flit_data;
        fvc_n = flit_vc;
        err_n = 1'b0;
        req_ready = 1'b0;
        data_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (load_en) fv_n = 1'b0;
                if (req_valid) begin
                    cap_x_n = req_dest_x;
                    cap_y_n = req_dest_y;
                    cap_type_n = req_type;
                    cap_order_n = req_order;
                    cap_len_n = req_len;
                    cap_vc_n = req_vc;
                    if (bad_dest) err_n = 1'b1;
                    else state_n = HEAD;
                end
            end
            HEAD: begin
                if (load_en) begin
                    fd_n = head_f;
                    fv_n = 1'b1;
                    fvc_n = cap_vc;
                    cnt_n = '0;
                    state_n = (cap_len != 8'd0) ? BODY : TAIL;
                end
            end
            BODY: begin
                data_ready = load_en;
                if (load_en) begin
                    if (data_valid) begin
                        fd_n = data;
                        fv_n = 1'b1;
                        fvc_n = cap_vc;
                        cnt_n = cnt + 8'd1;
                        if (cnt == cap_len - 8'd1) state_n = TAIL;
                    end else begin
                        fv_n = 1'b0;
                    end
                end
            end
            TAIL: begin
                if (load_en) begin
                    fd_n = tail_f;
                    fv_n = 1'b1;
                    fvc_n = cap_vc;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            cap_x <= '0;
            cap_y <= '0;
            cap_type <= '0;
            cap_order <= '0;
            cap_len <= '0;
            cap_vc <= '0;
            flit_valid <= 1'b0;
            flit_data <= '0;
            flit_vc <= '0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            cap_x <= cap_x_n;
            cap_y <= cap_y_n;
            cap_type <= cap_type_n;
            cap_order <= cap_order_n;
            cap_len <= cap_len_n;
            cap_vc <= cap_vc_n;
            flit_valid <= fv_n;
            flit_data <= fd_n;
            flit_vc <= fvc_n;
            err <= err_n;
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// Randomized bench for noc_packetizer: queue-based packet model,
// background payload source and flit sink with random gaps.
module tb_noc_packetizer;
    import Noc_parameters::*;

    localparam logic [1:0] SX = 2'd1;
    localparam logic [1:0] SY = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [1:0] req_dest_x = '0;
    logic [1:0] req_dest_y = '0;
    logic [2:0] req_type = '0;
    logic [7:0] req_order = '0;
    logic [7:0] req_len = '0;
    logic [1:0] req_vc = '0;
    logic data_valid = 1'b0;
    logic data_ready;
    logic [127:0] data = '0;
    logic flit_valid;
    logic flit_ready = 1'b0;
    logic [127:0] flit_data;
    logic [1:0] flit_vc;
    logic err;

    noc_packetizer #(.SRC_X(SX), .SRC_Y(SY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y),
        .req_type(req_type), .req_order(req_order),
        .req_len(req_len), .req_vc(req_vc),
        .data_valid(data_valid), .data_ready(data_ready),
        .data(data),
        .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_data(flit_data), .flit_vc(flit_vc),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int data_pct = 100;
    int ready_pct = 100;
    bit sink_auto = 1'b1;
    int err_cnt = 0;
    int dr_cnt = 0;
    int hs_cyc = 0;
    logic [127:0] beat_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    logic [1:0] expvc_q[$];
    logic [1:0] obsvc_q[$];
    int obs_cyc[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (sink_auto) flit_ready = ($urandom_range(99) < ready_pct);
        if (beat_q.size() > 0 && $urandom_range(99) < data_pct) begin
            data_valid = 1'b1;
            data = beat_q[0];
        end else begin
            data_valid = 1'b0;
            data = '0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (flit_valid && flit_ready) begin
            obs_q.push_back(flit_data);
            obsvc_q.push_back(flit_vc);
            obs_cyc.push_back(cyc);
        end
        if (data_valid && data_ready && beat_q.size() > 0)
            void'(beat_q.pop_front());
        if (err) err_cnt++;
        if (data_ready) dr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] head_of(logic [1:0] dx, logic [1:0] dy,
                                             logic [2:0] t, logic [7:0] o,
                                             logic [7:0] l);
        return {4'hA, SX, SY, dx, dy, t, o, l, 4'hB, 93'd0};
    endfunction

    function automatic logic [127:0] tail_of(logic [1:0] dx, logic [1:0] dy);
        return {4'hC, SX, SY, dx, dy, 112'd0, 4'hD};
    endfunction

    task automatic clear_q();
        exp_q.delete();
        expvc_q.delete();
        obs_q.delete();
        obsvc_q.delete();
        obs_cyc.delete();
    endtask

    task automatic issue(input logic [1:0] dx, input logic [1:0] dy,
                         input logic [2:0] t, input logic [7:0] o,
                         input logic [7:0] l, input logic [1:0] vc,
                         output bit ok);
        logic [127:0] b;
        if (dx < 2'd3 && dy < 2'd3) begin
            exp_q.push_back(head_of(dx, dy, t, o, l));
            expvc_q.push_back(vc);
            for (int i = 0; i < int'(l); i++) begin
                b = {$urandom, $urandom, $urandom, $urandom};
                beat_q.push_back(b);
                exp_q.push_back(b);
                expvc_q.push_back(vc);
            end
            exp_q.push_back(tail_of(dx, dy));
            expvc_q.push_back(vc);
        end
        @(posedge clk);
        #1;
        req_dest_x = dx;
        req_dest_y = dy;
        req_type = t;
        req_order = o;
        req_len = l;
        req_vc = vc;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                hs_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_n(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (flit_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset flit_valid: got %b want 0", flit_valid);
        end
        n_cmp++;
        if (flit_data !== 128'd0) begin
            n_bad++;
            $display("FAIL reset flit_data: got %h want 0", flit_data);
        end
        n_cmp++;
        if (flit_vc !== 2'd0) begin
            n_bad++;
            $display("FAIL reset flit_vc: got %0d want 0", flit_vc);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset err: got %b want 0", err);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset req_ready: got %b want 1", req_ready);
        end
        n_cmp++;
        if (data_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset data_ready: got %b want 0", data_ready);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [1:0] vc;
        clear_q();
        data_pct = 100;
        ready_pct = 100;
        vc = 2'($urandom_range(3));
        issue(2'd2, 2'd0, 3'd3, 8'd5, 8'd2, vc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic handshake: got none want req_ready");
        end
        wait_n(4, 50, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL basic count: got %0d want 4", obs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i] || obsvc_q[i] !== expvc_q[i]) begin
                    n_bad++;
                    $display("FAIL basic flit%0d: got %h/%0d want %h/%0d",
                             i, obs_q[i], obsvc_q[i], exp_q[i], expvc_q[i]);
                end
            end
            n_cmp++;
            if (obs_cyc[0] !== hs_cyc + 2) begin
                n_bad++;
                $display("FAIL basic latency: got cyc %0d want %0d",
                         obs_cyc[0], hs_cyc + 2);
            end
            n_cmp++;
            if (obs_cyc[3] - obs_cyc[0] !== 3) begin
                n_bad++;
                $display("FAIL basic rate: got span %0d want 3",
                         obs_cyc[3] - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_len0();
        bit ok;
        clear_q();
        dr_cnt = 0;
        issue(2'd0, 2'd1, 3'd1, 8'd9, 8'd0, 2'd2, ok);
        wait_n(2, 50, ok);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || obs_q.size() != 2) begin
            n_bad++;
            $display("FAIL len0 count: got %0d want 2", obs_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i] || obsvc_q[i] !== expvc_q[i]) begin
                    n_bad++;
                    $display("FAIL len0 flit%0d: got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (dr_cnt !== 0) begin
            n_bad++;
            $display("FAIL len0 data_ready: got %0d cycles want 0", dr_cnt);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [127:0] held;
        clear_q();
        sink_auto = 1'b0;
        flit_ready = 1'b1;
        issue(2'd1, 2'd1, 3'd2, 8'd7, 8'd3, 2'd1, ok);
        wait_n(2, 50, ok);
        @(posedge clk);
        #1;
        flit_ready = 1'b0;
        held = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) held = flit_data;
            n_cmp++;
            if (flit_valid !== 1'b1 || flit_data !== exp_q[2]) begin
                n_bad++;
                $display("FAIL stall hold%0d: got %b/%h want 1/%h",
                         i, flit_valid, flit_data, exp_q[2]);
            end
            n_cmp++;
            if (data_ready !== 1'b0 || flit_data !== held) begin
                n_bad++;
                $display("FAIL stall ready%0d: got dr %b data %h want 0/%h",
                         i, data_ready, flit_data, held);
            end
        end
        @(posedge clk);
        #1;
        ready_pct = 100;
        sink_auto = 1'b1;
        wait_n(5, 50, ok);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || obs_q.size() != 5) begin
            n_bad++;
            $display("FAIL stall count: got %0d want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL stall flit%0d: got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bad_dest();
        bit ok;
        clear_q();
        err_cnt = 0;
        issue(2'd3, 2'd1, 3'd0, 8'd1, 8'd4, 2'd3, ok);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_dest pulse: got err %b rdy %b want 1/1",
                     err, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL bad_dest width: got err %b want 0", err);
        end
        repeat (6) @(negedge clk);
        #1;
        n_cmp++;
        if (err_cnt !== 1 || obs_q.size() !== 0) begin
            n_bad++;
            $display("FAIL bad_dest quiet: got err %0d flits %0d want 1/0",
                     err_cnt, obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_q();
        data_pct = 100;
        ready_pct = 100;
        issue(2'd2, 2'd2, 3'd4, 8'd3, 8'd4, 2'd2, ok);
        wait_n(2, 50, ok);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        beat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        n_cmp++;
        if (flit_valid !== 1'b0 || req_ready !== 1'b1 || data_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid state: got fv %b rr %b dr %b want 0/1/0",
                     flit_valid, req_ready, data_ready);
        end
        issue(2'd0, 2'd0, 3'd6, 8'd2, 8'd1, 2'd3, ok);
        wait_n(3, 50, ok);
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || obs_q.size() != 3) begin
            n_bad++;
            $display("FAIL reset_mid count: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i] || obsvc_q[i] !== expvc_q[i]) begin
                    n_bad++;
                    $display("FAIL reset_mid flit%0d: got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_long();
        bit ok;
        logic [1:0] vc;
        clear_q();
        data_pct = 70;
        ready_pct = 70;
        vc = 2'($urandom_range(3));
        issue(2'd1, 2'd2, 3'd7, 8'hA5, 8'd255, vc, ok);
        wait_n(257, 5000, ok);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || obs_q.size() != 257) begin
            n_bad++;
            $display("FAIL long count: got %0d want 257", obs_q.size());
        end else begin
            for (int i = 0; i < 257; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i] || obsvc_q[i] !== vc) begin
                    n_bad++;
                    $display("FAIL long flit%0d: got %h/%0d want %h/%0d",
                             i, obs_q[i], obsvc_q[i], exp_q[i], vc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int total;
        clear_q();
        data_pct = 80;
        ready_pct = 80;
        for (int p = 0; p < 5; p++) begin
            issue(2'($urandom_range(2)), 2'($urandom_range(2)),
                  3'($urandom_range(7)), 8'($urandom_range(255)),
                  8'($urandom_range(6)), 2'($urandom_range(3)), ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL b2b handshake%0d: got none want req_ready", p);
            end
        end
        total = exp_q.size();
        wait_n(total, 2000, ok);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || obs_q.size() != total) begin
            n_bad++;
            $display("FAIL b2b count: got %0d want %0d", obs_q.size(), total);
        end else begin
            for (int i = 0; i < total; i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i] || obsvc_q[i] !== expvc_q[i]) begin
                    n_bad++;
                    $display("FAIL b2b flit%0d: got %h/%0d want %h/%0d",
                             i, obs_q[i], obsvc_q[i], exp_q[i], expvc_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_bad_dest();
        test_reset_mid();
        test_long();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
